uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning fpga_clk cycles per UART bit (minimum 4).
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning payload bits per frame (5..8).
REQ-003 SHALL have parameter PARITY, default 0, meaning 0 none, 1 odd, 2 even.
REQ-004 SHALL have parameter FIFO_DEPTH, default 16, meaning receive FIFO entries (power of 2, at least 2).
REQ-005 SHALL have port fpga_clk  in  1  single system clock; all logic on its rising edge.
REQ-006 SHALL have port fpga_rst_n  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port rx  in  1  asynchronous serial line, idle high.
REQ-008 SHALL have port rd_en  in  1  pop request for the FIFO head.
REQ-009 SHALL have port rd_data  out  DATA_BITS  FIFO head, first-word fall-through.
REQ-010 SHALL have port empty  out  1  FIFO holds 0 entries.
REQ-011 SHALL have port full  out  1  FIFO holds FIFO_DEPTH entries.
REQ-012 SHALL have port count  out  $clog2(FIFO_DEPTH)+1  current occupancy.
REQ-013 SHALL have ports frame_err, parity_err, overrun  out  1 each  sticky error flags.
REQ-014 SHALL have port clr_err  in  1  synchronous clear of all sticky flags.

Function
REQ-015 SHALL pass rx through a 2-flop synchronizer; all decisions use the synchronized value rxs.
REQ-016 SHALL implement FSM states IDLE, START, DATA, PAR, STOP, BRK.
REQ-017 IDLE: on rxs==0, go to START and clear the bit timer.
REQ-018 START: at timer==CLKS_PER_BIT/2-1, sample rxs; 0 -> DATA with timer cleared; 1 -> IDLE as a false start, with no flag and no push.
REQ-019 DATA: sample rxs every CLKS_PER_BIT cycles at bit midpoint, LSB first; after DATA_BITS samples go to PAR if PARITY!=0, else to STOP.
REQ-020 PAR: sample at midpoint; a mismatch against odd/even parity of the payload marks the frame bad-parity.
REQ-021 STOP: sample at midpoint; rxs==1 and parity good -> push payload and go to IDLE at once, so back-to-back frames are accepted.
REQ-022 STOP with rxs==0: set frame_err, discard the payload, go to BRK.
REQ-023 STOP with rxs==1 but bad parity: set parity_err, discard the payload, go to IDLE.
REQ-024 BRK: stay until rxs==1, then go to IDLE.
REQ-025 Push SHALL occur in the cycle after the stop-bit sample; empty deasserts and count increments on the following edge.
REQ-026 Push while full and rd_en==0: drop the byte, set overrun, leave FIFO contents unchanged.
REQ-027 Push and rd_en in the same cycle: both occur, count unchanged, no overrun, including when full.
REQ-028 rd_en while empty SHALL be ignored: no pointer or count change.
REQ-029 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-030 rd_data SHALL equal the oldest entry whenever empty==0; it is don't-care when empty.
REQ-031 A flag set event and clr_err in the same cycle: the set wins.

Reset
REQ-032 While fpga_rst_n==0: FSM in IDLE; synchronizer flops at 1; timer, bit counter, pointers and count at 0.
REQ-033 While fpga_rst_n==0: empty=1, full=0, rd_data=0, all sticky flags 0.
REQ-034 Assertion mid-frame SHALL abort the frame with no push, and the FIFO SHALL be emptied.
REQ-035 After release: the first frame is accepted only after a falling edge of rxs seen in IDLE.

Verification
REQ-036 CLKS_PER_BIT=4, 8N1: send 0x2A -> empty falls within 2 cycles after the stop sample; rd_data=0x2A; count=1.
REQ-037 Send 0x03, 0x2A back-to-back with a zero-length gap -> both pushed in order; pop twice -> empty=1.
REQ-038 PARITY=2: send 0x07 with parity bit 0 -> parity_err=1, no push; then clr_err pulse -> parity_err=0.
REQ-039 Stop bit held low for 20 bit times -> frame_err=1, FSM in BRK until rx high, next valid frame accepted.
REQ-040 FIFO_DEPTH=4: send 5 frames with no reads -> full=1, overrun=1, contents = first 4 bytes; repeat with rd_en pulsed at the 5th push -> no overrun.
REQ-041 rx low pulse of 1 cycle in IDLE -> false start, no flag, no push; fpga_rst_n low mid-DATA -> empty=1, no push.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1-style framing with optional parity) feeding a first-word
// fall-through receive FIFO, with sticky frame/parity/overrun error flags.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          fpga_clk,
    input  logic                          fpga_rst_n,
    input  logic                          rx,
    input  logic                          rd_en,
    input  logic                          clr_err,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun,
    output logic [2:0]                    fsm_state
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    LAST_BIT  = 4'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4,
        BRK   = 3'd5
    } state_t;

    state_t                 state;
    logic                   rx_meta;
    logic                   rxs;
    logic [TW-1:0]          timer;
    logic [3:0]             bit_cnt;
    logic [DATA_BITS-1:0]   shreg;
    logic                   par_bad;
    logic                   push;

    logic                   bit_tick;
    logic                   par_mismatch;
    logic                   frame_evt;
    logic                   parity_evt;
    logic                   overrun_evt;

    logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic                   do_wr;
    logic                   do_rd;

    assign fsm_state = state;

    // Synchronizer resets to the idle-line level so reset release is not a start edge.
    always_ff @(posedge fpga_clk or negedge fpga_rst_n) begin
        if (!fpga_rst_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    assign bit_tick = (timer == FULL_LAST);

    always_comb begin
        par_mismatch = 1'b0;
        if (PARITY == 1) begin
            par_mismatch = ~(^shreg ^ rxs);
        end else if (PARITY == 2) begin
            par_mismatch = ^shreg ^ rxs;
        end
    end

    assign frame_evt   = (state == STOP) && bit_tick && !rxs;
    assign parity_evt  = (state == STOP) && bit_tick && rxs && par_bad;
    assign overrun_evt = push && full && !rd_en;

    always_ff @(posedge fpga_clk or negedge fpga_rst_n) begin
        if (!fpga_rst_n) begin
            state   <= IDLE;
            timer   <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            par_bad <= 1'b0;
            push    <= 1'b0;
        end else begin
            push <= 1'b0;
            case (state)
                IDLE: begin
                    timer   <= '0;
                    bit_cnt <= '0;
                    if (!rxs) begin
                        state   <= START;
                        par_bad <= 1'b0;
                    end
                end
                START: begin
                    if (timer == HALF_LAST) begin
                        timer <= '0;
                        state <= rxs ? IDLE : DATA;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        timer   <= '0;
                        shreg   <= {rxs, shreg[DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            state <= (PARITY != 0) ? PAR : STOP;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                PAR: begin
                    if (bit_tick) begin
                        timer   <= '0;
                        par_bad <= par_mismatch;
                        state   <= STOP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_tick) begin
                        timer <= '0;
                        if (rxs) begin
                            push  <= !par_bad;
                            state <= IDLE;
                        end else begin
                            state <= BRK;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                BRK: begin
                    timer <= '0;
                    if (rxs) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A full FIFO still accepts a push when the head is popped in the same cycle.
    assign do_wr = push && (!full || rd_en);
    assign do_rd = rd_en && !empty;

    // shreg is stable during the push cycle: the next DATA sample is many cycles away.
    always_ff @(posedge fpga_clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= shreg;
        end
    end

    always_ff @(posedge fpga_clk or negedge fpga_rst_n) begin
        if (!fpga_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign empty   = (count == '0);
    assign full    = (count == CW'(FIFO_DEPTH));
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // A set event outranks a simultaneous clear.
    always_ff @(posedge fpga_clk or negedge fpga_rst_n) begin
        if (!fpga_rst_n) begin
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err  <= frame_evt   | (frame_err  & ~clr_err);
            parity_err <= parity_evt  | (parity_err & ~clr_err);
            overrun    <= overrun_evt | (overrun    & ~clr_err);
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: unit 0 is 8N1, unit 1 is 8E1, both with
// 4 clocks per bit and a 4-entry FIFO.
module tb_uart_rx_fifo;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx [2];
    logic       rd_en [2];
    logic       clr_err [2];
    logic [7:0] rd_data [2];
    logic       empty [2];
    logic       full [2];
    logic [2:0] cnt [2];
    logic       frame_err [2];
    logic       parity_err [2];
    logic       overrun [2];
    logic [2:0] fsm_state [2];

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] data;
        logic [7:0] exp_data;
        logic [2:0] exp_count;
    } vec0_t;

    typedef struct {
        logic [7:0] data;
        logic       pbit;
        logic [2:0] exp_count;
        logic       exp_perr;
    } vec1_t;

    vec0_t tab0 [5];
    vec1_t tab1 [5];

    always #5 clk = ~clk;

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(DEPTH)) u0 (
        .fpga_clk(clk), .fpga_rst_n(rst_n), .rx(rx[0]), .rd_en(rd_en[0]), .clr_err(clr_err[0]),
        .rd_data(rd_data[0]), .empty(empty[0]), .full(full[0]), .count(cnt[0]),
        .frame_err(frame_err[0]), .parity_err(parity_err[0]), .overrun(overrun[0]),
        .fsm_state(fsm_state[0])
    );

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .FIFO_DEPTH(DEPTH)) u1 (
        .fpga_clk(clk), .fpga_rst_n(rst_n), .rx(rx[1]), .rd_en(rd_en[1]), .clr_err(clr_err[1]),
        .rd_data(rd_data[1]), .empty(empty[1]), .full(full[1]), .count(cnt[1]),
        .frame_err(frame_err[1]), .parity_err(parity_err[1]), .overrun(overrun[1]),
        .fsm_state(fsm_state[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input int u, input logic v);
        rx[u] = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input int u, input logic [7:0] d, input bit use_par,
                              input logic pbit, input logic stop_v);
        send_bit(u, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(u, d[i]);
        if (use_par) send_bit(u, pbit);
        send_bit(u, stop_v);
    endtask

    task automatic pop(input int u, input string name);
        logic [7:0] e;
        e = exp_q.pop_front();
        check(name, 32'(rd_data[u]), 32'(e));
        rd_en[u] = 1'b1;
        @(negedge clk);
        rd_en[u] = 1'b0;
    endtask

    task automatic pulse_clr(input int u);
        clr_err[u] = 1'b1;
        @(negedge clk);
        clr_err[u] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tab0[0] = '{8'h2A, 8'h2A, 3'd1};
        tab0[1] = '{8'h00, 8'h00, 3'd1};
        tab0[2] = '{8'hFF, 8'hFF, 3'd1};
        tab0[3] = '{8'h81, 8'h81, 3'd1};
        tab0[4] = '{8'h5A, 8'h5A, 3'd1};
        // even parity: parity bit makes the total count of ones even
        tab1[0] = '{8'h07, 1'b0, 3'd0, 1'b1};
        tab1[1] = '{8'h07, 1'b1, 3'd1, 1'b0};
        tab1[2] = '{8'hFF, 1'b0, 3'd1, 1'b0};
        tab1[3] = '{8'h01, 1'b0, 3'd0, 1'b1};
        tab1[4] = '{8'h96, 1'b0, 3'd1, 1'b0};

        rst_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            rx[u] = 1'b1;
            rd_en[u] = 1'b0;
            clr_err[u] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check("rst_empty", 32'(empty[u]), 32'd1);
            check("rst_full", 32'(full[u]), 32'd0);
            check("rst_count", 32'(cnt[u]), 32'd0);
            check("rst_rd_data", 32'(rd_data[u]), 32'd0);
            check("rst_flags", 32'({frame_err[u], parity_err[u], overrun[u]}), 32'd0);
            check("rst_state", 32'(fsm_state[u]), 32'd0);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            send_frame(0, tab0[i].data, 1'b0, 1'b0, 1'b1);
            @(negedge clk);
            check("push_not_yet", 32'(empty[0]), 32'd1);
            @(negedge clk);
            check("push_empty", 32'(empty[0]), 32'd0);
            check("push_count", 32'(cnt[0]), 32'(tab0[i].exp_count));
            exp_q.push_back(tab0[i].exp_data);
            pop(0, "tab0_data");
            check("tab0_empty_after_pop", 32'(empty[0]), 32'd1);
        end

        rd_en[0] = 1'b1;
        @(negedge clk);
        rd_en[0] = 1'b0;
        check("rd_when_empty_count", 32'(cnt[0]), 32'd0);

        send_frame(0, 8'h03, 1'b0, 1'b0, 1'b1);
        send_frame(0, 8'h2A, 1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        check("b2b_count", 32'(cnt[0]), 32'd2);
        exp_q.push_back(8'h03);
        exp_q.push_back(8'h2A);
        pop(0, "b2b_first");
        pop(0, "b2b_second");
        check("b2b_empty", 32'(empty[0]), 32'd1);

        rx[0] = 1'b0;
        @(negedge clk);
        rx[0] = 1'b1;
        repeat (12) @(negedge clk);
        check("false_start_count", 32'(cnt[0]), 32'd0);
        check("false_start_flags", 32'({frame_err[0], parity_err[0], overrun[0]}), 32'd0);
        check("false_start_state", 32'(fsm_state[0]), 32'd0);

        send_frame(0, 8'h55, 1'b0, 1'b0, 1'b0);
        repeat (19 * CPB) @(negedge clk);
        check("brk_frame_err", 32'(frame_err[0]), 32'd1);
        check("brk_state", 32'(fsm_state[0]), 32'd5);
        check("brk_no_push", 32'(cnt[0]), 32'd0);
        rx[0] = 1'b1;
        repeat (4) @(negedge clk);
        check("brk_exit_idle", 32'(fsm_state[0]), 32'd0);
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        check("after_brk_count", 32'(cnt[0]), 32'd1);
        exp_q.push_back(8'h3C);
        pop(0, "after_brk_data");
        pulse_clr(0);
        check("frame_err_cleared", 32'(frame_err[0]), 32'd0);

        for (int i = 0; i < 5; i++) begin
            send_frame(0, 8'(8'h11 * (i + 1)), 1'b0, 1'b0, 1'b1);
            if (i < 4) exp_q.push_back(8'(8'h11 * (i + 1)));
        end
        repeat (2) @(negedge clk);
        check("ovr_full", 32'(full[0]), 32'd1);
        check("ovr_count", 32'(cnt[0]), 32'd4);
        check("ovr_flag", 32'(overrun[0]), 32'd1);
        for (int i = 0; i < 4; i++) pop(0, "ovr_contents");
        check("ovr_drained", 32'(empty[0]), 32'd1);
        pulse_clr(0);
        check("ovr_cleared", 32'(overrun[0]), 32'd0);

        for (int i = 0; i < 5; i++) begin
            send_frame(0, 8'(8'h60 + i), 1'b0, 1'b0, 1'b1);
            exp_q.push_back(8'(8'h60 + i));
        end
        @(negedge clk);
        pop(0, "ovr2_head");
        check("ovr2_no_overrun", 32'(overrun[0]), 32'd0);
        check("ovr2_full", 32'(full[0]), 32'd1);
        check("ovr2_count", 32'(cnt[0]), 32'd4);
        for (int i = 0; i < 4; i++) pop(0, "ovr2_contents");
        check("ovr2_drained", 32'(empty[0]), 32'd1);

        for (int i = 0; i < 5; i++) begin
            send_frame(1, tab1[i].data, 1'b1, tab1[i].pbit, 1'b1);
            repeat (2) @(negedge clk);
            check("par_count", 32'(cnt[1]), 32'(tab1[i].exp_count));
            check("par_err", 32'(parity_err[1]), 32'(tab1[i].exp_perr));
            if (tab1[i].exp_count != 0) begin
                exp_q.push_back(tab1[i].data);
                pop(1, "par_data");
            end
            if (tab1[i].exp_perr) begin
                pulse_clr(1);
                check("par_err_cleared", 32'(parity_err[1]), 32'd0);
            end
        end

        send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1);
        clr_err[1] = 1'b1;
        @(negedge clk);
        clr_err[1] = 1'b0;
        check("set_wins_over_clr", 32'(parity_err[1]), 32'd1);
        pulse_clr(1);
        check("set_wins_then_clr", 32'(parity_err[1]), 32'd0);

        send_frame(0, 8'h77, 1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        check("pre_rst_count", 32'(cnt[0]), 32'd1);
        send_bit(0, 1'b0);
        send_bit(0, 1'b1);
        send_bit(0, 1'b0);
        send_bit(0, 1'b1);
        check("mid_data_state", 32'(fsm_state[0]), 32'd2);
        rst_n = 1'b0;
        rx[0] = 1'b1;
        @(negedge clk);
        check("midrst_empty", 32'(empty[0]), 32'd1);
        check("midrst_count", 32'(cnt[0]), 32'd0);
        check("midrst_rd_data", 32'(rd_data[0]), 32'd0);
        check("midrst_state", 32'(fsm_state[0]), 32'd0);
        rst_n = 1'b1;
        exp_q.delete();
        repeat (60) @(negedge clk);
        check("postrst_no_push", 32'(cnt[0]), 32'd0);
        send_frame(0, 8'hC3, 1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        check("postrst_count", 32'(cnt[0]), 32'd1);
        exp_q.push_back(8'hC3);
        pop(0, "postrst_data");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
